phase_burst_packer: RTL and testbench

//  Parametrised multi-channel phase packer for the interferometer data path. Decimates the
//  per-sample phase stream (keeps every decim-th sample), collects FRAMES kept frames of
//  NUM_CH channels, then streams the burst out as OUT_W-bit words with valid/ready/last.

---
 rtl/phase_burst_packer.sv | 174 +++++++++++++++++
 tb/tb_phase_burst_packer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_burst_packer.sv
// Decimating multi-channel phase packer: gathers FRAMES kept frames into a burst and
// streams it as OUT_W-bit words over valid/ready/last, double-buffered with drop reporting.
module phase_burst_packer #(
    parameter int CH_W   = 16,
    parameter int NUM_CH = 5,
    parameter int FRAMES = 8,
    parameter int OUT_W  = 128,
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH*CH_W-1:0] in_data,
    input  logic                   in_valid,
    input  logic [31:0]            decim,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       ch_sel,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   ovf,
    input  logic                   ovf_clr,
    output logic [15:0]            drop_cnt
);

    localparam int FRAME_W = NUM_CH * CH_W;
    localparam int TOT     = FRAME_W * FRAMES;
    localparam int NW_ALL  = TOT / OUT_W;
    localparam int NW_ONE  = (FRAMES * CH_W) / OUT_W;
    localparam int WIDX_W  = (NW_ALL > 1) ? $clog2(NW_ALL) : 1;
    localparam int FIDX_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state, state_next;
    logic [WIDX_W-1:0]   widx, widx_next;
    logic                load;

    logic [31:0]         cnt, decim_eff;
    logic [FIDX_W-1:0]   fidx;
    logic                burst_mode, send_mode;
    logic [SEL_W-1:0]    burst_sel, sel_now, sel_eff;
    logic [FRAME_W-1:0]  fill_buf [FRAMES];
    logic [OUT_W-1:0]    send_buf [NW_ALL];

    logic                keep, first, complete, mode_eff;
    logic [FRAME_W-1:0]  slot_data, frame;
    logic [TOT-1:0]      burst_vec;
    logic [OUT_W-1:0]    burst_words [NW_ALL];
    logic [WIDX_W-1:0]   nw_last;
    logic                last_word, last_xfer, handoff, drop;

    // NOTE: every signal driven from always_comb gets a value before any branch,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        decim_eff = (decim == 32'd0) ? 32'd1 : decim;
        keep      = in_valid && (cnt >= decim_eff - 32'd1);
        first     = (fidx == '0);
        complete  = keep && (fidx == FIDX_W'(FRAMES - 1));
        sel_now   = (int'(ch_sel) >= NUM_CH) ? '0 : ch_sel;
        mode_eff  = first ? mode : burst_mode;
        sel_eff   = first ? sel_now : burst_sel;
        slot_data = mode_eff ? in_data : FRAME_W'(in_data[int'(sel_eff)*CH_W +: CH_W]);
    end

    // The final frame is taken straight from in_data so handoff happens on the completing edge.
    always_comb begin
        burst_vec = '0;
        frame     = '0;
        for (int f = 0; f < FRAMES; f++) begin
            frame = (f == FRAMES - 1) ? slot_data : fill_buf[f];
            if (mode_eff)
                burst_vec[TOT-1-f*FRAME_W -: FRAME_W] = frame;
            else
                burst_vec[TOT-1-f*CH_W -: CH_W] = frame[CH_W-1:0];
        end
        for (int k = 0; k < NW_ALL; k++)
            burst_words[k] = burst_vec[TOT-1-k*OUT_W -: OUT_W];
    end

    always_comb begin
        nw_last   = send_mode ? WIDX_W'(NW_ALL - 1) : WIDX_W'(NW_ONE - 1);
        last_word = (state == SEND) && (widx == nw_last);
        last_xfer = last_word && out_ready;
        handoff   = complete && ((state == IDLE) || last_xfer);
        drop      = complete && !handoff;
    end

    always_comb begin
        state_next = state;
        widx_next  = widx;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (handoff) begin
                    state_next = SEND;
                    widx_next  = '0;
                    load       = 1'b1;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (widx == nw_last) begin
                        widx_next = '0;
                        if (handoff)
                            load = 1'b1;
                        else
                            state_next = IDLE;
                    end else begin
                        widx_next = widx + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            widx  <= '0;
        end else begin
            state <= state_next;
            widx  <= widx_next;
        end
    end

    // NOTE: the burst buffers are reset explicitly because a reset must leave out_data at 0
    // and discard any partial or pending burst; this rules out plain RAM inference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            fidx       <= '0;
            burst_mode <= 1'b0;
            burst_sel  <= '0;
            send_mode  <= 1'b0;
            ovf        <= 1'b0;
            drop_cnt   <= '0;
            for (int f = 0; f < FRAMES; f++) fill_buf[f] <= '0;
            for (int k = 0; k < NW_ALL; k++) send_buf[k] <= '0;
        end else begin
            if (keep) begin
                cnt            <= '0;
                fill_buf[fidx] <= slot_data;
                fidx           <= complete ? '0 : fidx + 1'b1;
                if (first) begin
                    burst_mode <= mode;
                    burst_sel  <= sel_now;
                end
            end else if (in_valid) begin
                cnt <= cnt + 32'd1;
            end

            if (load) begin
                send_mode <= mode_eff;
                for (int k = 0; k < NW_ALL; k++) send_buf[k] <= burst_words[k];
            end

            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign out_valid = (state == SEND);
    assign out_last  = last_word;
    assign out_data  = send_buf[widx];

endmodule

// File: tb/tb_phase_burst_packer.sv
// Scoreboard bench for phase_burst_packer: a frame-level model queues expected words,
// a negedge monitor compares every presented word and pops it on transfer.
module tb_phase_burst_packer;

    localparam int CH_W   = 16;
    localparam int NUM_CH = 5;
    localparam int FRAMES = 8;
    localparam int OUT_W  = 128;
    localparam int SEL_W  = 3;
    localparam int FW     = NUM_CH * CH_W;

    logic                   clk, rst;
    logic [FW-1:0]          in_data;
    logic                   in_valid;
    logic [31:0]            decim;
    logic                   mode;
    logic [SEL_W-1:0]       ch_sel;
    logic [OUT_W-1:0]       out_data;
    logic                   out_valid, out_ready, out_last;
    logic                   ovf, ovf_clr;
    logic [15:0]            drop_cnt;

    phase_burst_packer #(.CH_W(CH_W), .NUM_CH(NUM_CH), .FRAMES(FRAMES), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .decim(decim),
        .mode(mode), .ch_sel(ch_sel), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .ovf(ovf), .ovf_clr(ovf_clr),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic [OUT_W:0] sb [$];
    bit mon_en  = 1'b0;
    bit push_en = 1'b1;

    int         mcnt, mfill, msel;
    logic       mmode;
    logic [FW-1:0] mframes [FRAMES];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] frame_val(input int n);
        logic [FW-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c*CH_W +: CH_W] = 16'((n << 4) | c);
        return v;
    endfunction

    function automatic void model_push();
        logic [FW*FRAMES-1:0] v;
        logic [OUT_W-1:0]     s;
        if (mmode) begin
            for (int f = 0; f < FRAMES; f++) v[FW*FRAMES-1-f*FW -: FW] = mframes[f];
            for (int k = 0; k < 5; k++)
                sb.push_back({(k == 4) ? 1'b1 : 1'b0, v[FW*FRAMES-1-k*OUT_W -: OUT_W]});
        end else begin
            for (int f = 0; f < FRAMES; f++) s[OUT_W-1-f*CH_W -: CH_W] = mframes[f][msel*CH_W +: CH_W];
            sb.push_back({1'b1, s});
        end
    endfunction

    task automatic send_frame(input logic [FW-1:0] d);
        int deff;
        deff     = (decim == 32'd0) ? 1 : int'(decim);
        in_data  = d;
        in_valid = 1'b1;
        if (mcnt >= deff - 1) begin
            mcnt = 0;
            if (mfill == 0) begin
                mmode = mode;
                msel  = (int'(ch_sel) >= NUM_CH) ? 0 : int'(ch_sel);
            end
            mframes[mfill] = d;
            mfill++;
            if (mfill == FRAMES) begin
                mfill = 0;
                if (push_en) model_push();
            end
        end else begin
            mcnt++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        checks++;
        if (sb.size() != 0) $display("FAIL %s_drain: %0d words still expected", name, sb.size());
        else passes++;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst && out_valid) begin
            checks++;
            if (sb.size() == 0)
                $display("FAIL word_unexpected: got last=%b data=%h, none expected", out_last, out_data);
            else if ({out_last, out_data} !== sb[0])
                $display("FAIL word: got %h want %h", {out_last, out_data}, sb[0]);
            else
                passes++;
            if (out_ready && sb.size() != 0) void'(sb.pop_front());
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passes++;
        checks++; if (out_last !== 1'b0) $display("FAIL reset_last: got %b want 0", out_last); else passes++;
        checks++; if (out_data !== '0) $display("FAIL reset_data: got %h want 0", out_data); else passes++;
        checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else passes++;
        checks++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop: got %h want 0", drop_cnt); else passes++;
        tick();
        tick();
        rst   = 1'b0;
        mcnt  = 0;
        mfill = 0;
    endtask

    task automatic test_full();
        decim = 32'd1; mode = 1'b1; out_ready = 1'b1;
        for (int n = 1; n <= 7; n++) send_frame(frame_val(n));
        checks++; if (out_valid !== 1'b0) $display("FAIL full_early: out_valid=%b want 0", out_valid); else passes++;
        send_frame(frame_val(8));
        checks++; if (out_valid !== 1'b1) $display("FAIL full_latency: out_valid=%b want 1", out_valid); else passes++;
        checks++; if (out_data[127:112] !== 16'h0014) $display("FAIL full_w0_top: got %h want 0014", out_data[127:112]); else passes++;
        checks++; if (out_last !== 1'b0) $display("FAIL full_w0_last: got %b want 0", out_last); else passes++;
        drain("full", 20);
    endtask

    task automatic test_decim();
        decim = 32'd3;
        for (int n = 1; n <= 24; n++) send_frame(frame_val(n + 16));
        drain("decim3", 20);
        decim = 32'd0;
        for (int n = 1; n <= 8; n++) send_frame(frame_val(n + 48));
        checks++; if (out_valid !== 1'b1) $display("FAIL decim0_latency: out_valid=%b want 1", out_valid); else passes++;
        drain("decim0", 20);
        decim = 32'd1;
    endtask

    task automatic test_single();
        mode = 1'b0; ch_sel = 3'd2;
        for (int n = 1; n <= 8; n++) send_frame(frame_val(n + 64));
        checks++; if (out_last !== 1'b1) $display("FAIL single_last: got %b want 1", out_last); else passes++;
        checks++; if (out_data[127:112] !== 16'h0412) $display("FAIL single_top: got %h want 0412", out_data[127:112]); else passes++;
        drain("single", 10);
        ch_sel = 3'd7;
        for (int n = 1; n <= 8; n++) begin
            send_frame(frame_val(n + 72));
            ch_sel = 3'd3;
        end
        drain("single_sel", 10);
        mode = 1'b1; ch_sel = 3'd0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        for (int n = 1; n <= 8; n++) send_frame(frame_val(n + 80));
        tick();
        tick();
        out_ready = 1'b0;
        repeat (20) tick();
        checks++; if (out_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", out_valid); else passes++;
        out_ready = 1'b1;
        drain("stall", 20);
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int n = 1; n <= 8; n++) send_frame(frame_val(n + 96));
        checks++; if (ovf !== 1'b0) $display("FAIL ovf_early: got %b want 0", ovf); else passes++;
        push_en = 1'b0;
        for (int n = 1; n <= 8; n++) send_frame(frame_val(n + 104));
        push_en = 1'b1;
        checks++; if (ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovf); else passes++;
        checks++; if (drop_cnt !== 16'd1) $display("FAIL ovf_count: got %0d want 1", drop_cnt); else passes++;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++; if (ovf !== 1'b0) $display("FAIL ovf_clr: got %b want 0", ovf); else passes++;
        checks++; if (drop_cnt !== 16'd1) $display("FAIL ovf_clr_count: got %0d want 1", drop_cnt); else passes++;
        out_ready = 1'b1;
        drain("ovf", 20);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int n = 1; n <= 24; n++) send_frame(frame_val(n + 128));
        drain("stream", 40);
        // Stall three words so the last word of burst A transfers on burst B's completing edge.
        for (int i = 1; i <= 16; i++) begin
            send_frame(frame_val(i + 160));
            if (i == 8)  out_ready = 1'b0;
            if (i == 11) out_ready = 1'b1;
        end
        checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", out_valid); else passes++;
        checks++; if (out_data[127:112] !== 16'h0A94) $display("FAIL b2b_top: got %h want 0a94", out_data[127:112]); else passes++;
        drain("b2b", 20);
        checks++; if (drop_cnt !== 16'd1) $display("FAIL b2b_drop: got %0d want 1", drop_cnt); else passes++;
        checks++; if (ovf !== 1'b0) $display("FAIL b2b_ovf: got %b want 0", ovf); else passes++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int n = 1; n <= 11; n++) send_frame(frame_val(n + 192));
        rst = 1'b1;
        sb.delete();
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", out_valid); else passes++;
        checks++; if (out_last !== 1'b0) $display("FAIL rstmid_last: got %b want 0", out_last); else passes++;
        checks++; if (out_data !== '0) $display("FAIL rstmid_data: got %h want 0", out_data); else passes++;
        checks++; if (drop_cnt !== 16'd0) $display("FAIL rstmid_drop: got %0d want 0", drop_cnt); else passes++;
        tick();
        tick();
        rst   = 1'b0;
        mcnt  = 0;
        mfill = 0;
        for (int n = 1; n <= 8; n++) send_frame(frame_val(n + 210));
        drain("rstmid", 20);
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; decim = 32'd1; mode = 1'b1;
        ch_sel = '0; out_ready = 1'b1; ovf_clr = 1'b0;
        mcnt = 0; mfill = 0; msel = 0; mmode = 1'b1;
        test_reset();
        mon_en = 1'b1;
        test_full();
        test_decim();
        test_single();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
